// File: rtl/delay_requester.sv
// Initiator side of the PC-stall handshake: queues stall requests, strobes the
// delay counter with delayEn/delayLen and tracks its pcEn stall/release response.
module delay_requester #(
    parameter int DEPTH       = 4,
    parameter int CNT_W       = 8,
    parameter int PULSE_W     = 2,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    input  logic [CNT_W-1:0]           req_len,
    output logic                       req_ready,
    output logic                       delayEn,
    output logic [CNT_W-1:0]           delayLen,
    input  logic                       pcEn,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout_err,
    input  logic                       err_clr,
    output logic [$clog2(DEPTH+1)-1:0] pending
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [OCC_W-1:0] DEPTH_OCC  = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);
    localparam logic [TMO_W-1:0] PULSE_LAST = TMO_W'(PULSE_W - 1);
    localparam logic [TMO_W-1:0] ACK_LAST   = TMO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LOW,
        WAIT_HIGH,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   count_q, count_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               saw_low_q, saw_low_d;
    logic               delay_en_q, delay_en_d;
    logic [CNT_W-1:0]   delay_len_q, delay_len_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               timeout_err_q, timeout_err_d;

    logic               push;
    logic               pop;
    logic               timeout_set;
    logic [CNT_W-1:0]   head_len;

    // Small FIFO storage: combinational head read so IDLE can latch it directly.
    logic [CNT_W-1:0]   mem_q [DEPTH];

    assign req_ready   = (count_q < DEPTH_OCC);
    assign push        = req_valid && req_ready;
    assign head_len    = mem_q[rd_ptr_q];

    assign delayEn     = delay_en_q;
    assign delayLen    = delay_len_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign pending     = count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= req_len;
        end
    end

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        saw_low_d   = saw_low_q;
        delay_len_d = delay_len_q;
        timeout_set = 1'b0;
        pop         = 1'b0;

        case (state_q)
            IDLE: begin
                // A stalled counter ignores strobes, so wait for pcEn before issuing.
                if ((count_q != '0) && pcEn) begin
                    delay_len_d = head_len;
                    tmo_d       = '0;
                    saw_low_d   = 1'b0;
                    state_d     = (head_len != '0) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                tmo_d = tmo_q + 1'b1;
                if (!pcEn) begin
                    saw_low_d = 1'b1;
                end
                if (tmo_q >= PULSE_LAST) begin
                    state_d = (saw_low_q || !pcEn) ? WAIT_HIGH : WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!pcEn) begin
                    state_d = WAIT_HIGH;
                end else if (tmo_q >= ACK_LAST) begin
                    timeout_set = 1'b1;
                    pop         = 1'b1;
                    delay_len_d = '0;
                    state_d     = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (pcEn) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                pop         = 1'b1;
                delay_len_d = '0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Outputs are registered copies of the next-state decode.
    always_comb begin
        delay_en_d = (state_d == ISSUE);
        done_d     = (state_d == DONE);
        busy_d     = (state_d != IDLE);
        if (timeout_set) begin
            timeout_err_d = 1'b1;
        end else if (err_clr) begin
            timeout_err_d = 1'b0;
        end else begin
            timeout_err_d = timeout_err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            tmo_q         <= '0;
            saw_low_q     <= 1'b0;
            delay_en_q    <= 1'b0;
            delay_len_q   <= '0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            tmo_q         <= tmo_d;
            saw_low_q     <= saw_low_d;
            delay_en_q    <= delay_en_d;
            delay_len_q   <= delay_len_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_delay_requester.sv
// Directed bench for delay_requester: hand-timed vectors plus a simple delay
// counter model used for the FIFO drain sequence.
module tb_delay_requester;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [7:0] req_len = '0;
    logic       req_ready;
    logic       delayEn;
    logic [7:0] delayLen;
    logic       pcEn;
    logic       busy;
    logic       done;
    logic       timeout_err;
    logic       err_clr = 1'b0;
    logic [2:0] pending;

    logic       auto_mode = 1'b0;
    logic       man_pcen = 1'b1;
    logic       resp_pcen = 1'b1;
    logic [7:0] resp_cnt = '0;

    int n_checks = 0;
    int n_pass = 0;

    int en_cycles = 0;
    int done_cnt = 0;
    int issue_cnt = 0;
    int issued [64];
    logic prev_en = 1'b0;

    assign pcEn = auto_mode ? resp_pcen : man_pcen;

    always #5 clk = ~clk;

    delay_requester #(
        .DEPTH(4), .CNT_W(8), .PULSE_W(2), .ACK_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready),
        .delayEn(delayEn), .delayLen(delayLen), .pcEn(pcEn),
        .busy(busy), .done(done), .timeout_err(timeout_err),
        .err_clr(err_clr), .pending(pending)
    );

    // Delay counter model: stalls for delayLen cycles after seeing a strobe.
    always @(posedge clk) begin
        if (!auto_mode) begin
            resp_pcen <= 1'b1;
            resp_cnt  <= '0;
        end else if (resp_pcen && delayEn) begin
            resp_pcen <= 1'b0;
            resp_cnt  <= delayLen;
        end else if (!resp_pcen) begin
            if (resp_cnt <= 8'd1) resp_pcen <= 1'b1;
            else                  resp_cnt  <= resp_cnt - 8'd1;
        end
    end

    always @(negedge clk) begin
        if (delayEn) en_cycles <= en_cycles + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (delayEn && !prev_en) begin
            issued[issue_cnt % 64] <= int'(delayLen);
            issue_cnt <= issue_cnt + 1;
        end
        prev_en <= delayEn;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, d0, i0;
        int lens [5];
        lens = '{3, 4, 5, 6, 7};

        // Reset state
        #12;
        check("rst_delayEn", int'(delayEn), 0);
        check("rst_delayLen", int'(delayLen), 0);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_timeout_err", int'(timeout_err), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_req_ready", int'(req_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // 1: single request of length 10
        e0 = en_cycles; d0 = done_cnt;
        req_valid = 1'b1; req_len = 8'd10;
        tick();
        req_valid = 1'b0;
        check("t1_pending_after_push", int'(pending), 1);
        tick();
        check("t1_delayEn_c1", int'(delayEn), 1);
        check("t1_delayLen_issue", int'(delayLen), 10);
        check("t1_busy", int'(busy), 1);
        tick();
        check("t1_delayEn_c2", int'(delayEn), 1);
        man_pcen = 1'b0;
        tick();
        check("t1_delayEn_dropped", int'(delayEn), 0);
        check("t1_delayLen_wait", int'(delayLen), 10);
        repeat (9) tick();
        man_pcen = 1'b1;
        check("t1_no_early_done", int'(done), 0);
        tick();
        check("t1_done", int'(done), 1);
        check("t1_delayLen_done", int'(delayLen), 10);
        tick();
        check("t1_done_single", int'(done), 0);
        check("t1_pending_end", int'(pending), 0);
        check("t1_busy_end", int'(busy), 0);
        check("t1_delayLen_cleared", int'(delayLen), 0);
        check("t1_en_cycles", en_cycles - e0, 2);
        check("t1_done_count", done_cnt - d0, 1);

        // 2: FIFO fill while the counter is stalled, then drain
        man_pcen = 1'b0;
        tick();
        d0 = done_cnt; i0 = issue_cnt;
        for (int k = 0; k < 5; k++) begin
            req_valid = 1'b1;
            req_len = 8'(lens[k]);
            check($sformatf("t2_req_ready_%0d", k), int'(req_ready), (k < 4) ? 1 : 0);
            tick();
        end
        req_valid = 1'b0;
        check("t2_pending_full", int'(pending), 4);
        repeat (3) tick();
        check("t2_no_delayEn", int'(delayEn), 0);
        check("t2_no_issue", issue_cnt - i0, 0);
        check("t2_idle_busy", int'(busy), 0);
        auto_mode = 1'b1;
        for (int c = 0; c < 300 && (done_cnt - d0) < 4; c++) tick();
        repeat (3) tick();
        check("t2_done_count", done_cnt - d0, 4);
        check("t2_issue_count", issue_cnt - i0, 4);
        for (int k = 0; k < 4; k++)
            check($sformatf("t2_issue_order_%0d", k), issued[(i0 + k) % 64], lens[k]);
        check("t2_pending_end", int'(pending), 0);
        auto_mode = 1'b0;
        man_pcen = 1'b1;
        tick();

        // 3: acknowledge timeout
        d0 = done_cnt;
        req_valid = 1'b1; req_len = 8'd5;
        tick();
        req_valid = 1'b0;
        tick();
        check("t3_delayEn_rise", int'(delayEn), 1);
        repeat (15) tick();
        check("t3_no_early_timeout", int'(timeout_err), 0);
        check("t3_pending_before", int'(pending), 1);
        tick();
        check("t3_timeout_err", int'(timeout_err), 1);
        check("t3_pending_dropped", int'(pending), 0);
        check("t3_busy_idle", int'(busy), 0);
        check("t3_delayLen_cleared", int'(delayLen), 0);
        check("t3_no_done", done_cnt - d0, 0);
        tick();
        check("t3_sticky", int'(timeout_err), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t3_cleared", int'(timeout_err), 0);

        // 4: zero-length request completes without a strobe
        e0 = en_cycles; d0 = done_cnt;
        req_valid = 1'b1; req_len = 8'd0;
        tick();
        req_valid = 1'b0;
        tick();
        check("t4_done", int'(done), 1);
        check("t4_delayEn", int'(delayEn), 0);
        tick();
        check("t4_pending", int'(pending), 0);
        check("t4_en_cycles", en_cycles - e0, 0);
        check("t4_done_count", done_cnt - d0, 1);

        // 5: asynchronous reset during ISSUE with entries queued
        man_pcen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_valid = 1'b1;
            req_len = 8'(8 + k);
            tick();
        end
        req_valid = 1'b0;
        check("t5_pending_queued", int'(pending), 3);
        man_pcen = 1'b1;
        tick();
        check("t5_in_issue", int'(delayEn), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_delayEn", int'(delayEn), 0);
        check("t5_rst_pending", int'(pending), 0);
        check("t5_rst_busy", int'(busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        i0 = issue_cnt;
        repeat (5) tick();
        check("t5_no_reissue", issue_cnt - i0, 0);
        check("t5_idle_busy", int'(busy), 0);

        // 6: pcEn stall seen during ISSUE and already over before WAIT
        d0 = done_cnt;
        req_valid = 1'b1; req_len = 8'd4;
        tick();
        req_valid = 1'b0;
        tick();
        check("t6_delayEn", int'(delayEn), 1);
        man_pcen = 1'b0;
        tick();
        man_pcen = 1'b1;
        tick();
        check("t6_delayEn_off", int'(delayEn), 0);
        tick();
        check("t6_done", int'(done), 1);
        check("t6_no_timeout", int'(timeout_err), 0);
        tick();
        check("t6_pending", int'(pending), 0);
        check("t6_done_count", done_cnt - d0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/delay_requester.md
Name: delay_requester

Overview:
- Initiator side of the PC-stall handshake.
- Queues stall requests from the control path and issues each one to the delay counter.
- Each issue is a delayEn pulse plus a stall length.
- Tracks the counter's pcEn response (falls = stall started, rises = stall finished) and reports completion or an acknowledge timeout.
- Sits between the control/decode logic and the delay counter in the pineapple core.

Parameters:
- DEPTH, 4: request FIFO entries, any value ≥1.
- CNT_W, 8: width of the requested stall length.
- PULSE_W, 2: cycles delayEn is held high per issue, ≥1.
- ACK_TIMEOUT, 16: cycles allowed from delayEn rise to pcEn low, ≥PULSE_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  stall request present.
- req_len  in  CNT_W  requested stall length in cycles.
- req_ready  out  1  FIFO can accept a request.
- delayEn  out  1  issue strobe to the delay counter, registered.
- delayLen  out  CNT_W  length of the request in flight, registered.
- pcEn  in  1  delay counter response; 1 = PC running, 0 = stalled. Same clock domain.
- busy  out  1  a request is in flight (state ≠ IDLE).
- done  out  1  one-cycle pulse when a request completes.
- timeout_err  out  1  sticky acknowledge-timeout flag.
- err_clr  in  1  clears timeout_err.
- pending  out  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - delayEn=0, delayLen=0, done=0, busy=0, timeout_err=0, pending=0, req_ready=1.
  - FIFO is emptied and the FSM returns to IDLE.
  - Applies mid-issue too: delayEn drops immediately and the in-flight request is discarded.
- FIFO:
  - Push when req_valid && req_ready.
  - req_ready = (pending < DEPTH), based on occupancy only. When full, no push is accepted even in a pop cycle.
  - Push and pop in the same cycle leave pending unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, DONE.
- IDLE:
  - If FIFO is non-empty and pcEn=1, latch the head length into delayLen.
  - If head length ≠ 0, go to ISSUE.
  - If head length = 0, go to DONE without asserting delayEn.
  - If pcEn=0 (counter still stalling), stay in IDLE. The responder ignores strobes while stalled, so no strobe is sent.
- ISSUE:
  - delayEn=1 for exactly PULSE_W cycles; the timeout counter starts at 0 in the first ISSUE cycle.
  - If pcEn=0 is sampled in any ISSUE cycle, set saw_low.
  - After the last ISSUE cycle, go to WAIT_HIGH if saw_low is set, else WAIT_LOW.
- WAIT_LOW:
  - delayEn=0.
  - On pcEn=0, go to WAIT_HIGH.
  - If the timeout counter reaches ACK_TIMEOUT-1 with pcEn still 1:
    - set timeout_err;
    - pop and drop the request;
    - delayLen=0; go to IDLE;
    - no done pulse.
- WAIT_HIGH:
  - Wait for pcEn=1, then go to DONE. No timeout in this state.
- DONE:
  - done=1 for one cycle; pop the FIFO head; delayLen=0; go to IDLE.
- Throughput: back-to-back requests have at least one IDLE cycle between DONE and the next ISSUE.
- busy is 1 in all states except IDLE.
- timeout_err:
  - Set has priority over err_clr in the same cycle.
  - Stays set across further requests until cleared.
- delayLen holds constant from ISSUE entry to DONE/timeout exit.

Test Plan:
1. Single request: req_len=10, pcEn driven low 1 cycle after delayEn rises and high 10 cycles later → delayEn high exactly 2 cycles, delayLen=10 throughout, one done pulse 1 cycle after pcEn rises, pending 1→0.
2. FIFO fill: 5 requests on consecutive cycles with pcEn held low → first 4 accepted, req_ready=0 on 5th, pending=4, no delayEn; release pcEn → 4 issues in order, 4 done pulses.
3. Timeout: req_len=5, pcEn held 1 → timeout_err set 16 cycles after delayEn rise, no done, pending→0; err_clr=1 for 1 cycle → timeout_err=0.
4. Zero length: req_len=0 → done pulse, delayEn never asserted, pending→0.
5. Reset mid-operation: rst_n low during ISSUE with 3 entries queued → delayEn=0 immediately, pending=0, busy=0; after release, no issue occurs without a new request.
6. Fast acknowledge: pcEn falls during the first ISSUE cycle → FSM skips WAIT_LOW, done pulses after pcEn returns high, no timeout.
